// File: rtl/memoria_dados_sinc.sv
// rtl/memoria_dados_sinc.sv - synchronous data memory with registered read and post-reset clear sweep
// Optional stored parity bit enabled by MEMORIA_DADOS_PARIDADE_EN.
module memoria_dados_sinc #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 24,
    parameter int LARG_END     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LARG_END-1:0] endereco,
    input  logic [LARGURA-1:0]  dado,
    input  logic                EscrMemo,
    input  logic                LerMemo,
`ifdef MEMORIA_DADOS_PARIDADE_EN
    input  logic                forcaErroParidade,
`endif
    output logic [LARGURA-1:0]  dadoLido,
    output logic                dadoValido,
    output logic                ocupado,
    output logic                erroEndereco
`ifdef MEMORIA_DADOS_PARIDADE_EN
    ,
    output logic                erroParidade
`endif
);

`ifdef MEMORIA_DADOS_PARIDADE_EN
    localparam int LARG_PALAVRA = LARGURA + 1;
`else
    localparam int LARG_PALAVRA = LARGURA;
`endif
    localparam int LARG_IDX = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam logic [LARG_END:0]   PROF_L = (LARG_END+1)'(PROFUNDIDADE);
    localparam logic [LARG_END-1:0] ULTIMO = LARG_END'(PROFUNDIDADE - 1);

    typedef enum logic {LIMPANDO, PRONTO} estado_t;

    estado_t                 estado, prox_estado;
    logic [LARG_END-1:0]     cont;
    logic [LARG_PALAVRA-1:0] memo [PROFUNDIDADE];
    logic [LARG_PALAVRA-1:0] palavra_escrita;
    logic [LARG_PALAVRA-1:0] palavra_lida;
    logic [LARG_IDX-1:0]     idx;
    logic [LARG_IDX-1:0]     idx_cont;
    logic                    em_faixa;

    assign em_faixa = ({1'b0, endereco} < PROF_L);
    assign idx      = endereco[LARG_IDX-1:0];
    assign idx_cont = cont[LARG_IDX-1:0];
    assign ocupado  = (estado == LIMPANDO);
    assign palavra_lida = memo[idx];

`ifdef MEMORIA_DADOS_PARIDADE_EN
    // Even parity over the data; the test hook flips it to plant a fault.
    assign palavra_escrita = {(^dado) ^ forcaErroParidade, dado};
`else
    assign palavra_escrita = dado;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= LIMPANDO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        if (estado == LIMPANDO && cont == ULTIMO) begin
            prox_estado = PRONTO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cont <= '0;
        end else if (estado == LIMPANDO) begin
            cont <= cont + 1'b1;
        end
    end

    // Storage has no reset of its own; the sweep zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (estado == LIMPANDO) begin
                memo[idx_cont] <= '0;
            end else if (EscrMemo && em_faixa) begin
                memo[idx] <= palavra_escrita;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dadoLido     <= '0;
            dadoValido   <= 1'b0;
            erroEndereco <= 1'b0;
`ifdef MEMORIA_DADOS_PARIDADE_EN
            erroParidade <= 1'b0;
`endif
        end else begin
            dadoValido   <= 1'b0;
            erroEndereco <= 1'b0;
`ifdef MEMORIA_DADOS_PARIDADE_EN
            erroParidade <= 1'b0;
`endif
            if (estado == PRONTO) begin
                if (EscrMemo) begin
                    erroEndereco <= !em_faixa;
                end else if (LerMemo) begin
                    dadoValido   <= 1'b1;
                    erroEndereco <= !em_faixa;
                    if (em_faixa) begin
                        dadoLido <= palavra_lida[LARGURA-1:0];
`ifdef MEMORIA_DADOS_PARIDADE_EN
                        erroParidade <= ^palavra_lida;
`endif
                    end else begin
                        dadoLido <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_memoria_dados_sinc.sv
// tb/tb_memoria_dados_sinc.sv - scoreboard bench for memoria_dados_sinc
module tb_memoria_dados_sinc;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] endereco;
    logic [7:0] dado;
    logic       EscrMemo;
    logic       LerMemo;
    logic [7:0] dadoLido;
    logic       dadoValido;
    logic       ocupado;
    logic       erroEndereco;
`ifdef MEMORIA_DADOS_PARIDADE_EN
    logic       forcaErroParidade;
    logic       erroParidade;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       v;
        logic       e;
        logic       p;
        logic [7:0] d;
    } esperado_t;

    esperado_t fila[$];
    logic [7:0] modelo [24];

    always #5 clk = ~clk;

    memoria_dados_sinc #(.LARGURA(8), .PROFUNDIDADE(24), .LARG_END(8)) dut (
        .clk(clk),
        .reset(reset),
        .endereco(endereco),
        .dado(dado),
        .EscrMemo(EscrMemo),
        .LerMemo(LerMemo),
`ifdef MEMORIA_DADOS_PARIDADE_EN
        .forcaErroParidade(forcaErroParidade),
`endif
        .dadoLido(dadoLido),
        .dadoValido(dadoValido),
        .ocupado(ocupado),
        .erroEndereco(erroEndereco)
`ifdef MEMORIA_DADOS_PARIDADE_EN
        ,
        .erroParidade(erroParidade)
`endif
    );

    logic strobe_p;
`ifdef MEMORIA_DADOS_PARIDADE_EN
    assign strobe_p = erroParidade;
`else
    assign strobe_p = 1'b0;
`endif

    always @(negedge clk) begin
        if (dadoValido || erroEndereco || strobe_p) begin
            total++;
            if (fila.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: valido=%b erro=%b par=%b dado=%02h, none required",
                         dadoValido, erroEndereco, strobe_p, dadoLido);
            end else begin
                esperado_t x;
                x = fila.pop_front();
                if (dadoValido !== x.v || erroEndereco !== x.e || strobe_p !== x.p ||
                    (x.v && dadoLido !== x.d)) begin
                    bad++;
                    $display("FAIL response: got v=%b e=%b p=%b d=%02h, required v=%b e=%b p=%b d=%02h",
                             dadoValido, erroEndereco, strobe_p, dadoLido, x.v, x.e, x.p, x.d);
                end
            end
        end
    end

    task automatic checa(input string nome, input logic [31:0] atual, input logic [31:0] req);
        total++;
        if (atual !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nome, atual, req);
        end
    endtask

    task automatic escrever(input logic [7:0] a, input logic [7:0] d, input logic forca);
        endereco = a; dado = d; EscrMemo = 1'b1; LerMemo = 1'b0;
`ifdef MEMORIA_DADOS_PARIDADE_EN
        forcaErroParidade = forca;
`endif
        if (a >= 24) fila.push_back('{v: 1'b0, e: 1'b1, p: 1'b0, d: 8'h00});
        else if (!forca) modelo[a] = d;
        @(posedge clk); #1;
        EscrMemo = 1'b0;
`ifdef MEMORIA_DADOS_PARIDADE_EN
        forcaErroParidade = 1'b0;
`endif
    endtask

    task automatic ler(input logic [7:0] a, input logic [7:0] d, input logic p);
        endereco = a; EscrMemo = 1'b0; LerMemo = 1'b1;
        fila.push_back('{v: 1'b1, e: (a >= 24), p: p, d: d});
        @(posedge clk); #1;
        LerMemo = 1'b0;
    endtask

    task automatic aplica_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        checa("reset_ocupado", ocupado, 1);
        checa("reset_valido", dadoValido, 0);
        checa("reset_dado", dadoLido, 0);
        reset = 1'b0;
    endtask

    task automatic espera_limpeza(input string nome);
        int n = 0;
        while (ocupado && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checa(nome, n, 24);
    endtask

    initial begin
        reset = 1'b1; endereco = '0; dado = '0; EscrMemo = 1'b0; LerMemo = 1'b0;
`ifdef MEMORIA_DADOS_PARIDADE_EN
        forcaErroParidade = 1'b0;
`endif
        for (int i = 0; i < 24; i++) modelo[i] = 8'h00;
        #2;
        aplica_reset(2);
        espera_limpeza("clear_len");
        ler(8'd23, 8'h00, 1'b0);

        escrever(8'd5, 8'hA5, 1'b0);
        ler(8'd5, 8'hA5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checa("hold_dado", dadoLido, 8'hA5);
        checa("hold_valido", dadoValido, 0);

        ler(8'd24, 8'h00, 1'b0);
        escrever(8'd24, 8'h77, 1'b0);
        escrever(8'd200, 8'h11, 1'b0);

        // Write and read together: only the write takes effect, no strobe.
        endereco = 8'd2; dado = 8'h3C; EscrMemo = 1'b1; LerMemo = 1'b1;
        modelo[2] = 8'h3C;
        @(posedge clk); #1;
        EscrMemo = 1'b0; LerMemo = 1'b0;
        ler(8'd2, 8'h3C, 1'b0);

        // Back-to-back sweep of every word.
        for (int i = 0; i < 24; i++) ler(8'(i), modelo[i], 1'b0);

`ifdef MEMORIA_DADOS_PARIDADE_EN
        escrever(8'd3, 8'h01, 1'b1);
        ler(8'd3, 8'h01, 1'b1);
        escrever(8'd3, 8'h01, 1'b0);
        ler(8'd3, 8'h01, 1'b0);
`endif

        escrever(8'd7, 8'hFF, 1'b0);
        ler(8'd7, 8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checa("queue_before_reset", fila.size(), 0);

        aplica_reset(1);
        // Requests during the sweep must be ignored without strobes.
        endereco = 8'd24; EscrMemo = 1'b1; LerMemo = 1'b1; dado = 8'h55;
        repeat (10) @(posedge clk);
        #1;
        checa("mid_sweep_ocupado", ocupado, 1);
        EscrMemo = 1'b0;
        aplica_reset(1);
        endereco = 8'd7;
        espera_limpeza("clear_len_restart");
        LerMemo = 1'b0;
        for (int i = 0; i < 24; i++) modelo[i] = 8'h00;
        ler(8'd7, 8'h00, 1'b0);
        ler(8'd5, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checa("queue_empty", fila.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memoria_dados_sinc.md
# memoria_dados_sinc

Parametrised, fully synchronous data memory for the nRisc datapath, the next-generation replacement for the fixed 8-bit x 24-word data store. It adds configurable width and depth, a registered read with an explicit valid strobe, out-of-range address detection, and a hardware clear sequencer that zeroes every word after reset while signalling busy. It sits between the ALU address output and the write-back mux.

## Interface

- LARGURA, 8, data word width in bits
- PROFUNDIDADE, 24, number of words; legal addresses 0..PROFUNDIDADE-1
- LARG_END, 8, address width; must satisfy 2^LARG_END >= PROFUNDIDADE
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high; restarts the clear sequence
- endereco  in  LARG_END  word address
- dado  in  LARGURA  write data
- EscrMemo  in  1  write request
- LerMemo  in  1  read request
- forcaErroParidade  in  1  test hook, only present with MEMORIA_DADOS_PARIDADE_EN
- dadoLido  out  LARGURA  registered read data
- dadoValido  out  1  one-cycle strobe, dadoLido updated this cycle
- ocupado  out  1  clear sequence in progress; requests ignored
- erroEndereco  out  1  one-cycle strobe, request addressed >= PROFUNDIDADE
- erroParidade  out  1  one-cycle strobe with dadoValido, only present with MEMORIA_DADOS_PARIDADE_EN

## Operation

- States: LIMPANDO and PRONTO. A clear counter `cont` has width LARG_END.
- Edge with reset=1: state <= LIMPANDO, cont <= 0, dadoLido <= 0, dadoValido <= 0, erroEndereco <= 0, erroParidade <= 0. No memory write occurs on this edge. This applies whatever the current state, so reset mid-sweep restarts at word 0.
- LIMPANDO, reset=0: Memo[cont] <= 0, with parity bit 0. cont <= cont+1. When cont == PROFUNDIDADE-1, state <= PRONTO.
- ocupado is combinational: (state == LIMPANDO).
- EscrMemo and LerMemo are ignored while ocupado=1. No strobes are produced.
- PRONTO, EscrMemo=1: write has priority over read.
  - endereco < PROFUNDIDADE: Memo[endereco] <= dado.
  - Otherwise: no write, and erroEndereco=1 for one cycle.
  - dadoValido stays 0, even if LerMemo=1.
- PRONTO, LerMemo=1, EscrMemo=0: dadoLido <= Memo[endereco] and dadoValido=1 for one cycle.
  - Out of range: dadoLido <= 0, dadoValido=1, erroEndereco=1.
- No request: dadoLido holds its last value. All strobes are 0.
- Memory contents are not initialised from a file. The bench must apply reset and wait for ocupado=0 before issuing requests.

## Timing

- Read latency is 1 cycle: a request sampled at edge N produces dadoLido/dadoValido valid after edge N.
- Write then read: a write at edge N followed by a read at edge N+1 returns the new data after N+1. No forwarding is needed.
- Clear duration: after the last edge with reset=1, ocupado stays 1 for exactly PROFUNDIDADE edges, then drops to 0.
- While reset is held high: ocupado=1 and cont=0.
- Strobes (dadoValido, erroEndereco, erroParidade) are registered. Each lasts exactly one cycle per accepted request. Back-to-back reads give a continuous dadoValido high.

## Configuration

- MEMORIA_DADOS_PARIDADE_EN defined:
  - Each word stores LARGURA+1 bits. The extra bit is even parity of dado, XORed with forcaErroParidade on write.
  - On an in-range read, erroParidade=1 alongside dadoValido if the stored parity mismatches the stored data.
  - Ports forcaErroParidade and erroParidade exist.
- Undefined: storage is LARGURA bits, and neither port exists. Behaviour is otherwise identical.

## Test plan

- Reset for 2 cycles, then release -> ocupado=1 for exactly 24 cycles. After that, a read of address 23 returns 0x00 with dadoValido=1 one cycle later.
- Write 0xA5 to address 5, read address 5 on the next cycle -> dadoLido=0xA5 and dadoValido=1 one cycle after the read; dadoLido holds 0xA5 while idle.
- Read or write address 24 -> erroEndereco=1 for one cycle. Read returns dadoLido=0x00; write leaves all words unchanged, confirmed by reading addresses 0..23.
- EscrMemo=1 and LerMemo=1 together, writing 0x3C to address 2 -> dadoValido=0 and the write happens; a subsequent read of address 2 returns 0x3C.
- Write 0xFF to address 7, reset, then assert reset again 10 cycles into the sweep -> ocupado stays high for 24 cycles after the second release; address 7 reads back 0x00; requests during the sweep produce no strobes.
- With MEMORIA_DADOS_PARIDADE_EN: write 0x01 to address 3 with forcaErroParidade=1, then read it -> dadoLido=0x01, dadoValido=1, erroParidade=1. A normal write/read of the same word gives erroParidade=0.
